seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Decodes a multiplexed, active-low 7-segment display bus back into hex digits; the receiving end of the segment encoding the display driver produces.
- Watches segment and anode lines and waits for each digit's pattern to settle before sampling it.
- Assembles the digits into a frame word and flags blank or illegal patterns.
- Used by self-check logic and board-level loopback tests to read back what the display shows.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits / anode lines (1..8).
- STABLE_CYCLES, 4, consecutive clocks {seg_in, an_in} must be unchanged before a sample is taken (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- seg_in  input  7  segment lines, active-low (0 = lit). Bit 6 = a, bit 5 = b … bit 0 = g.
- an_in  input  NUM_DIGITS  digit enables, active-low, one-hot. Bit i selects digit i; digit 0 is the least-significant nibble.
- value  output  4*NUM_DIGITS  decoded frame word. Nibble i = digit i.
- blank  output  NUM_DIGITS  per-digit flag: pattern was 7'b1111111 (nibble reads 0).
- err  output  NUM_DIGITS  per-digit flag: pattern was illegal (nibble reads 0).
- frame_valid  output  1  one-cycle pulse when value/blank/err update.
- an_err  output  1  sticky flag: an_in was stable with zero or more than one line low; cleared only by reset.

Behaviour:
- Reset: all outputs, shadow registers, capture mask and stability counter go to 0. Previous-input register loads all-ones. Reset has priority every cycle; asserting it mid-frame discards partial captures and produces no frame_valid.
- Legal patterns (seg_in to hex):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F
  - 1111111 = blank.
  - Any other pattern = illegal.
- Stability counter:
  - Each cycle {seg_in, an_in} is compared with its registered copy from the previous cycle.
  - On mismatch: counter cleared to 0 and the sampled flag cleared.
  - On match: counter increments, saturating at STABLE_CYCLES.
- Sample event: fires for exactly one cycle, when all hold:
  - the counter reaches STABLE_CYCLES;
  - the sampled flag is clear;
  - an_in has exactly one bit low.
- On a sample event, digit i = index of the low bit:
  - shadow nibble i, blank_i and err_i are written from the decode;
  - mask bit i is set;
  - the sampled flag is set, so a held digit is sampled once only.
- Stable but not one-hot: no sample, an_err set; shadow and mask unchanged.
- Re-sampling digit i before the frame completes overwrites its shadow entries; this is not an error.
- Frame completion: on the clock edge after the sample that makes the mask all-ones:
  - value/blank/err load from the shadow registers;
  - frame_valid pulses high for one cycle;
  - mask clears.
  - If another sample lands in that same cycle, it is written to shadow and sets its mask bit in the freshly cleared mask; it counts toward the next frame.
- Latency: a digit held from cycle c is sampled in cycle c+STABLE_CYCLES+1. If it completes the frame, frame_valid is high in cycle c+STABLE_CYCLES+2.
- Outputs hold between frames; there is no timeout.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package seg_pkg:
  - localparams SEG_0..SEG_F and SEG_BLANK (7-bit active-low patterns, bit order a..g, MSB = a);
  - SEG_W = 7.
  - The display driver and this block both draw their patterns from it.
- One combinational sub-module, seg_pattern_decode:
  - input seg[6:0];
  - outputs hex[3:0], is_blank, is_illegal.
- Sequencing (compare register, counter, mask, shadows, frame strobe) lives in seg_scan_decoder.

Test Plan:
- Basic frame: after reset, hold an_in=1110/seg=0000110, then 1101/1001111, 1011/0000001, 0111/0001000, each for 8 cycles, with STABLE_CYCLES=4. Expect one frame_valid pulse, value=16'hA013, blank=0, err=0. The pulse comes 6 cycles after the digit-3 pattern first appears.
- Glitch rejection: digit 0 shows 0010010, toggles to 0000000 for 2 cycles, returns to 0010010 and holds. Expect exactly one sample, and nibble 0 = 2 in the next frame.
- Blank and illegal: digit 1 = 1111111, digit 2 = 1010101, digits 0 and 3 = 0000000. Expect value=16'h8008, blank=4'b0010, err=4'b0100.
- Bad anode: hold an_in=1100 for 10 cycles. Expect an_err=1, no sample, mask unchanged. A subsequent legal frame completes normally with an_err still 1.
- Overwrite and hold: digit 0 shows 5 then 6 before digits 1–3 arrive (all = F). Expect value=16'hFFF6. Holding digit 3 for 50 cycles yields only one frame_valid.
- Reset mid-frame: capture digits 0–1, pulse rst_n low for 1 cycle, then capture digits 2–3 only. Expect no frame_valid and value=0. Capturing digits 0–1 afterwards produces frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment pattern set, active-low, bit order a..g (MSB = a).
// Both the display driver and the scan decoder draw from these constants.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed display bus: active-low segment lines plus active-low anodes.
// master = display driver side, slave = scan decoder side.
interface seg_scan_decoder_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [SEG_W-1:0]      seg_in;
  logic [NUM_DIGITS-1:0] an_in;

  modport master (
    output seg_in,
    output an_in
  );

  modport slave (
    input seg_in,
    input an_in
  );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to hex decode.
// Ports: seg (active-low a..g) -> hex, is_blank, is_illegal (hex=0 unless legal).
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       hex,
  output logic             is_blank,
  output logic             is_illegal
);

  always_comb begin
    hex        = 4'h0;
    is_blank   = 1'b0;
    is_illegal = 1'b0;
    unique case (seg)
      SEG_0:     hex = 4'h0;
      SEG_1:     hex = 4'h1;
      SEG_2:     hex = 4'h2;
      SEG_3:     hex = 4'h3;
      SEG_4:     hex = 4'h4;
      SEG_5:     hex = 4'h5;
      SEG_6:     hex = 4'h6;
      SEG_7:     hex = 4'h7;
      SEG_8:     hex = 4'h8;
      SEG_9:     hex = 4'h9;
      SEG_A:     hex = 4'hA;
      SEG_B:     hex = 4'hB;
      SEG_C:     hex = 4'hC;
      SEG_D:     hex = 4'hD;
      SEG_E:     hex = 4'hE;
      SEG_F:     hex = 4'hF;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed active-low 7-seg display back into a hex frame word.
// Ports: clk, rst_n (sync, active-low), bus (slave: seg_in, an_in),
//   value/blank/err (per-digit frame), frame_valid (pulse), an_err (sticky).
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_scan_decoder_if.slave       bus,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_valid,
  output logic                    an_err
);

  localparam int IN_W = SEG_W + NUM_DIGITS;
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [IN_W-1:0]         cur;
  logic [IN_W-1:0]         prev;
  logic [CW-1:0]           cnt;
  logic                    sampled;
  logic                    match;
  logic                    stable;
  logic                    onehot;
  logic                    sample;
  logic [NUM_DIGITS-1:0]   lows;

  logic [3:0]              dec_hex;
  logic                    dec_blank;
  logic                    dec_ill;

  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_err;
  logic [NUM_DIGITS-1:0]   mask;

  logic [4*NUM_DIGITS-1:0] val_n;
  logic [NUM_DIGITS-1:0]   blank_n;
  logic [NUM_DIGITS-1:0]   err_n;
  logic [NUM_DIGITS-1:0]   mask_n;
  logic                    done;

  assign cur    = {bus.seg_in, bus.an_in};
  assign lows   = ~bus.an_in;
  assign match  = (cur == prev);
  assign stable = match && (cnt == CNT_MAX);
  assign onehot = $onehot(lows);
  assign sample = stable && !sampled && onehot;

  seg_pattern_decode u_dec (
    .seg        (bus.seg_in),
    .hex        (dec_hex),
    .is_blank   (dec_blank),
    .is_illegal (dec_ill)
  );

  // Merge the current sample into the shadow view. The frame is
  // committed on the same edge that writes its last digit, so the
  // output registers take the merged view rather than the old shadow.
  always_comb begin
    val_n   = sh_val;
    blank_n = sh_blank;
    err_n   = sh_err;
    mask_n  = mask;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sample && lows[i]) begin
        val_n[4*i +: 4] = dec_hex;
        blank_n[i]      = dec_blank;
        err_n[i]        = dec_ill;
        mask_n[i]       = 1'b1;
      end
    end
    done = &mask_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev        <= '1;
      cnt         <= '0;
      sampled     <= 1'b0;
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_err      <= '0;
      mask        <= '0;
      value       <= '0;
      blank       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      prev <= cur;

      if (!match) begin
        cnt     <= '0;
        sampled <= 1'b0;
      end else begin
        if (cnt != CNT_MAX)
          cnt <= cnt + 1'b1;
        if (sample)
          sampled <= 1'b1;
      end

      if (stable && !onehot)
        an_err <= 1'b1;

      sh_val      <= val_n;
      sh_blank    <= blank_n;
      sh_err      <= err_n;
      frame_valid <= done;

      if (done) begin
        value <= val_n;
        blank <= blank_n;
        err   <= err_n;
        mask  <= '0;
      end else begin
        mask  <= mask_n;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed frame values.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_seg_scan_decoder;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;
  logic        an_err;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int f0;

  always #5 clk = ~clk;

  seg_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .value       (value),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid),
    .an_err      (an_err)
  );

  always @(posedge clk)
    if (frame_valid === 1'b1)
      fv_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic show(input logic [3:0] an,
                      input logic [6:0] seg,
                      input int n);
    bus.an_in  = an;
    bus.seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.an_in  = 4'b1110;
    bus.seg_in = SEG_3;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_an_err", 32'(an_err), 32'h0);
    rst_n = 1'b1;

    // Basic frame 0xA013, with exact frame_valid latency.
    f0 = fv_cnt;
    show(4'b1110, SEG_3, 8);
    show(4'b1101, SEG_1, 8);
    show(4'b1011, SEG_0, 8);
    bus.an_in  = 4'b0111;
    bus.seg_in = SEG_A;
    repeat (5) @(negedge clk);
    check("basic_fv_early", 32'(frame_valid), 32'h0);
    @(negedge clk);
    check("basic_fv_on_time", 32'(frame_valid), 32'h1);
    repeat (2) @(negedge clk);
    check("basic_value", 32'(value), 32'hA013);
    check("basic_blank", 32'(blank), 32'h0);
    check("basic_err", 32'(err), 32'h0);
    check("basic_fv_count", 32'(fv_cnt - f0), 32'h1);

    // Glitch on the frame-completing digit must not commit early.
    f0 = fv_cnt;
    show(4'b1101, SEG_4, 8);
    show(4'b1011, SEG_7, 8);
    show(4'b0111, SEG_9, 8);
    show(4'b1110, SEG_2, 3);
    show(4'b1110, SEG_8, 2);
    show(4'b1110, SEG_2, 8);
    check("glitch_value", 32'(value), 32'h9742);
    check("glitch_fv_count", 32'(fv_cnt - f0), 32'h1);

    // Blank and illegal patterns.
    f0 = fv_cnt;
    show(4'b1110, SEG_8, 8);
    show(4'b1101, SEG_BLANK, 8);
    show(4'b1011, 7'b1010101, 8);
    show(4'b0111, SEG_8, 8);
    check("bi_value", 32'(value), 32'h8008);
    check("bi_blank", 32'(blank), 32'h2);
    check("bi_err", 32'(err), 32'h4);
    check("bi_an_err", 32'(an_err), 32'h0);
    check("bi_fv_count", 32'(fv_cnt - f0), 32'h1);

    // Bad anode mid-frame: no sample, mask kept, frame still completes.
    f0 = fv_cnt;
    show(4'b1110, SEG_1, 8);
    show(4'b1101, SEG_5, 8);
    show(4'b1100, SEG_8, 10);
    check("an_err_set", 32'(an_err), 32'h1);
    check("an_no_frame", 32'(fv_cnt - f0), 32'h0);
    show(4'b1011, SEG_6, 8);
    show(4'b0111, SEG_E, 8);
    check("an_value", 32'(value), 32'hE651);
    check("an_fv_count", 32'(fv_cnt - f0), 32'h1);
    check("an_err_sticky", 32'(an_err), 32'h1);

    // Overwrite digit 0, then hold the last digit for a long time.
    f0 = fv_cnt;
    show(4'b1110, SEG_5, 8);
    show(4'b1110, SEG_6, 8);
    show(4'b1101, SEG_F, 8);
    show(4'b1011, SEG_F, 8);
    show(4'b0111, SEG_F, 50);
    check("ow_value", 32'(value), 32'hFFF6);
    check("ow_fv_count", 32'(fv_cnt - f0), 32'h1);

    // Reset mid-frame discards digits 0-1.
    show(4'b1110, SEG_3, 8);
    show(4'b1101, SEG_1, 8);
    f0 = fv_cnt;
    rst_n      = 1'b0;
    bus.an_in  = 4'b1011;
    bus.seg_in = SEG_2;
    @(negedge clk);
    rst_n = 1'b1;
    show(4'b1011, SEG_2, 8);
    show(4'b0111, SEG_8, 8);
    check("mid_rst_no_frame", 32'(fv_cnt - f0), 32'h0);
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_an_err", 32'(an_err), 32'h0);
    show(4'b1110, SEG_4, 8);
    show(4'b1101, SEG_D, 8);
    check("mid_rst_frame", 32'(fv_cnt - f0), 32'h1);
    check("mid_rst_value2", 32'(value), 32'h82D4);
    check("mid_rst_blank", 32'(blank), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
